// File: rtl/hash_pkg.sv
// Shared types and constants for the hash-core request arbiter.
package hash_pkg;

    // Default beat width of the requester/core byte stream.
    localparam int HASH_DATA_W = 8;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    // True in the states where the core is busy with a message and the watchdog runs.
    function automatic logic is_core_phase(input arb_state_t st);
        logic res;
        case (st)
            START, STREAM, FLUSH: res = 1'b1;
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hash_req_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan candidates starting at the pointer; the first hit wins.
    always_comb begin : pick
        int               cand_v;
        logic [IDX_W-1:0] sel_v;
        logic             found_v;
        gnt_o   = '0;
        idx_o   = '0;
        found_v = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_v = int'(ptr_i) + off;
            cand_v = (cand_v >= NUM_REQ) ? (cand_v - NUM_REQ) : cand_v;
            sel_v  = IDX_W'(cand_v);
            if (!found_v && req_i[sel_v]) begin
                found_v      = 1'b1;
                idx_o        = sel_v;
                gnt_o[sel_v] = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        any_o = found_v;
    end

endmodule

// File: rtl/hash_req_arbiter.sv
// Shares one hash core among NUM_REQ byte-stream requesters: round-robin
// grant per message, stream forwarding, digest return and a hang watchdog.
module hash_req_arbiter
    import hash_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = HASH_DATA_W,
    parameter int DIGEST_W = 32,
    parameter int TMO_W    = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_eof,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DIGEST_W-1:0]         rsp_digest,
    output logic                        rsp_err,
    input  logic [NUM_REQ-1:0]          rsp_ack,
    output logic                        core_start,
    output logic                        core_dr,
    output logic [DATA_W-1:0]           core_data,
    output logic                        core_eof,
    input  logic                        core_rtr,
    input  logic                        core_h_ready,
    input  logic [DIGEST_W-1:0]         core_digest,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0]    owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [TMO_W-1:0]      wdog_q, wdog_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    cand_s;
    logic [NUM_REQ-1:0]    pick_gnt_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_any_s;
    logic [DATA_W-1:0]     owner_data_s;
    logic                  owner_valid_s;
    logic                  owner_eof_s;
    logic                  beat_s;
    logic                  wdog_max_s;

    logic [NUM_REQ-1:0]    req_ready_s;
    logic [NUM_REQ-1:0]    rsp_valid_s;
    logic [DIGEST_W-1:0]   rsp_digest_s;
    logic                  rsp_err_s;
    logic                  core_start_s;
    logic                  core_dr_s;
    logic [DATA_W-1:0]     core_data_s;
    logic                  core_eof_s;

    // A requester with either a beat or a pending EOF competes for the core.
    assign cand_s = req_valid | req_eof;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (cand_s),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    assign owner_data_s  = req_data[owner_q*DATA_W +: DATA_W];
    assign owner_valid_s = req_valid[owner_q];
    assign owner_eof_s   = req_eof[owner_q];
    assign wdog_max_s    = &wdog_q;

    // Next-state, datapath updates and stream/response outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        owner_oh_d   = owner_oh_q;
        ptr_d        = ptr_q;
        wdog_d       = wdog_q;
        digest_d     = digest_q;
        err_d        = err_q;
        req_ready_s  = '0;
        rsp_valid_s  = '0;
        rsp_digest_s = '0;
        rsp_err_s    = 1'b0;
        core_start_s = 1'b0;
        core_dr_s    = 1'b0;
        core_data_s  = '0;
        core_eof_s   = 1'b0;
        beat_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    owner_d    = pick_idx_s;
                    owner_oh_d = pick_gnt_s;
                    wdog_d     = '0;
                    state_d    = START;
                end else begin
                    state_d    = IDLE;
                end
            end

            START: begin
                core_start_s = 1'b1;
                wdog_d       = '0;
                state_d      = STREAM;
            end

            STREAM: begin
                core_data_s = owner_data_s;
                core_dr_s   = owner_valid_s & ~owner_eof_s;
                beat_s      = core_dr_s & core_rtr;
                if (owner_eof_s) begin
                    // EOF wins over any beat; a digest already ready skips FLUSH.
                    core_eof_s = 1'b1;
                    wdog_d     = '0;
                    if (core_h_ready) begin
                        digest_d = core_digest;
                        state_d  = RESP;
                    end else begin
                        state_d  = FLUSH;
                    end
                end else if (beat_s) begin
                    req_ready_s = owner_oh_q;
                    wdog_d      = '0;
                end else if (wdog_max_s) begin
                    err_d    = 1'b1;
                    digest_d = '0;
                    wdog_d   = '0;
                    state_d  = RESP;
                end else begin
                    wdog_d   = wdog_q + 1'b1;
                end
            end

            FLUSH: begin
                core_eof_s = 1'b1;
                if (core_h_ready) begin
                    digest_d = core_digest;
                    wdog_d   = '0;
                    state_d  = RESP;
                end else if (wdog_max_s) begin
                    err_d    = 1'b1;
                    digest_d = '0;
                    wdog_d   = '0;
                    state_d  = RESP;
                end else begin
                    wdog_d   = wdog_q + 1'b1;
                end
            end

            RESP: begin
                rsp_valid_s  = owner_oh_q;
                rsp_digest_s = digest_q;
                rsp_err_s    = err_q;
                if (rsp_ack[owner_q]) begin
                    ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : (owner_q + 1'b1);
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ownership, pointer, watchdog and digest registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            digest_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
            wdog_q     <= is_core_phase(state_q) ? wdog_d : wdog_q;
            digest_q   <= digest_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_s;
    assign rsp_digest = rsp_digest_s;
    assign rsp_err    = rsp_err_s;
    assign core_start = core_start_s;
    assign core_dr    = core_dr_s;
    assign core_data  = core_data_s;
    assign core_eof   = core_eof_s;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Randomized self-checking bench for hash_req_arbiter: requesters, a hash
// core model and a transaction-level scoreboard with round-robin prediction.
module tb_hash_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GW = 32;
    localparam int TW = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_eof = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [GW-1:0]     rsp_digest;
    logic              rsp_err;
    logic [N-1:0]      rsp_ack = '0;
    logic              core_start;
    logic              core_dr;
    logic [DW-1:0]     core_data;
    logic              core_eof;
    logic              core_rtr = 1'b0;
    logic              core_h_ready = 1'b0;
    logic [GW-1:0]     core_digest = '0;
    logic              busy;

    hash_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DIGEST_W(GW), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_eof(req_eof), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_digest(rsp_digest), .rsp_err(rsp_err), .rsp_ack(rsp_ack),
        .core_start(core_start), .core_dr(core_dr), .core_data(core_data), .core_eof(core_eof),
        .core_rtr(core_rtr), .core_h_ready(core_h_ready), .core_digest(core_digest), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Requester model
    logic [7:0] msg [N][32];
    int  len [N];
    int  sent [N];
    bit  active [N];
    int  reload [N];

    // Scoreboard / core model
    int  model_ptr = 0;
    int  cur_owner = 0;
    bit  in_txn = 0, phase_stream = 0, eof_seen = 0, h_done = 0, rsp_seen = 0;
    int  h_cnt = 0, ack_cnt = 0;
    bit  hr_now = 0, hr_check = 0, ack_now = 0;
    logic [31:0] rx_hash;
    int  starts = 0, tot_beats = 0, cyc = 0, eof_cyc = 0, since_ack = 0;
    bit  chk_start_lat = 0;
    int  grant_log [$];
    logic [N-1:0]  last_rsp;
    logic [GW-1:0] last_dig;
    logic          last_err;
    // Modes
    bit  fixed_dig = 0, hang = 0, eager_en = 0, stall_en = 0, junk_en = 0;
    int  rtr_pct = 100, bp_at = -1, bp_left = 0, bp_cycles = 0, bp_viol = 0;
    bit  bp_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fnv(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'h0100_0193;
    endfunction

    function automatic logic [31:0] msg_hash(input int i);
        logic [31:0] h = 32'h811C_9DC5;
        for (int k = 0; k < len[i]; k++) h = fnv(h, msg[i][k]);
        return h;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int predict_owner();
        for (int off = 0; off < N; off++)
            if (active[(model_ptr + off) % N]) return (model_ptr + off) % N;
        return -1;
    endfunction

    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (active[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_msg(input int i, input int l);
        for (int k = 0; k < l; k++) msg[i][k] = 8'($urandom);
        len[i] = l; sent[i] = 0; active[i] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin active[i] = 0; sent[i] = 0; len[i] = 0; reload[i] = 0; end
        model_ptr = 0; in_txn = 0; phase_stream = 0; eof_seen = 0; h_done = 0; rsp_seen = 0;
        h_cnt = 0; hr_check = 0; chk_start_lat = 0; bp_left = 0; bp_at = -1;
    endtask

    // Drive all inputs for the current cycle from the model state.
    task automatic drive();
        bit stall, h;
        for (int i = 0; i < N; i++) begin
            stall = stall_en && in_txn && phase_stream && (i == cur_owner) && ($urandom_range(0, 3) == 0);
            req_valid[i] = active[i] && (sent[i] < len[i]) && !stall;
            req_eof[i]   = active[i] && (sent[i] == len[i]);
            req_data[i*DW +: DW] = (active[i] && sent[i] < len[i]) ? msg[i][sent[i]] : 8'($urandom);
        end
        if (bp_at >= 0 && in_txn && phase_stream && sent[cur_owner] == bp_at) begin
            bp_left = 5; bp_at = -1;
        end
        bp_cyc = 0;
        if (bp_left > 0) begin core_rtr = 1'b0; bp_cyc = 1; bp_left--; end
        else core_rtr = ($urandom_range(0, 99) < rtr_pct);
        h = 0;
        if (in_txn && !hang && !h_done && !rsp_seen) begin
            if (eager_en && phase_stream && req_eof[cur_owner]) h = 1;
            else if (h_cnt > 0) begin h_cnt--; h = (h_cnt == 0); end
        end else if (junk_en && (!in_txn || rsp_seen)) begin
            h = ($urandom_range(0, 1) == 1);
        end
        hr_now = h && in_txn && !rsp_seen;
        if (hr_now) h_done = 1;
        core_h_ready = h;
        core_digest  = hr_now ? (fixed_dig ? 32'hDEAD_BEEF : rx_hash) : $urandom;
        rsp_ack = '0; ack_now = 0;
        if (in_txn && rsp_seen) begin
            rsp_ack = N'($urandom) & ~onehot(cur_owner);
            if (ack_cnt == 0) begin rsp_ack[cur_owner] = 1'b1; ack_now = 1; end
            else ack_cnt--;
        end
    endtask

    // Sample outputs mid-cycle, compare and advance the model.
    task automatic observe();
        bit beat;
        int o;
        cyc++; since_ack++;
        check("req_ready_onehot0", $onehot0(req_ready), 1);
        check("rsp_valid_onehot0", $onehot0(rsp_valid), 1);
        if (!busy) check("core_idle_zero", {core_start, core_dr, core_eof, core_data}, 0);
        beat = core_dr & core_rtr;
        check("req_ready", req_ready, (in_txn && beat) ? onehot(cur_owner) : '0);
        if (bp_cyc && in_txn) begin
            bp_cycles++;
            if (req_ready != '0) bp_viol++;
            check("bp_data", {core_dr, core_data}, {1'b1, msg[cur_owner][sent[cur_owner]]});
        end
        if (in_txn && beat) begin
            if (sent[cur_owner] < len[cur_owner]) begin
                check("beat_data", core_data, msg[cur_owner][sent[cur_owner]]);
                rx_hash = fnv(rx_hash, core_data);
                sent[cur_owner]++; tot_beats++;
            end else check("beat_overrun", sent[cur_owner], len[cur_owner] - 1);
        end
        if (in_txn && core_eof && !eof_seen) begin
            eof_seen = 1; phase_stream = 0; eof_cyc = cyc;
            check("eof_after_all_beats", sent[cur_owner], len[cur_owner]);
            if (!h_done && !hang) h_cnt = $urandom_range(1, 6);
        end
        if (core_start) begin
            starts++;
            o = predict_owner();
            if (in_txn || o < 0) check("unexpected_start", {in_txn, o[7:0]}, {1'b0, 8'h00});
            else begin
                if (chk_start_lat) check("ack_to_start_lat", since_ack, 2);
                cur_owner = o; in_txn = 1; phase_stream = 1; eof_seen = 0; h_done = 0;
                rsp_seen = 0; rx_hash = 32'h811C_9DC5; grant_log.push_back(o);
            end
            chk_start_lat = 0;
        end
        if (hr_check) begin check("hready_to_rsp_lat", rsp_valid[cur_owner], 1); hr_check = 0; end
        if (hr_now) hr_check = 1;
        if (in_txn && !rsp_seen && rsp_valid != '0) begin
            rsp_seen = 1; ack_cnt = $urandom_range(0, 3);
            last_rsp = rsp_valid; last_dig = rsp_digest; last_err = rsp_err;
            check("rsp_digest", rsp_digest, hang ? 32'h0 : (fixed_dig ? 32'hDEAD_BEEF : msg_hash(cur_owner)));
            check("rsp_err", rsp_err, hang);
            if (hang) check("wdog_window", (cyc - eof_cyc >= (1 << TW) - 1) && (cyc - eof_cyc <= (1 << TW) + 2), 1);
        end
        check("rsp_valid", rsp_valid, (in_txn && rsp_seen) ? onehot(cur_owner) : '0);
        if (in_txn && rsp_seen && ack_now) begin
            active[cur_owner] = 0; model_ptr = (cur_owner + 1) % N;
            in_txn = 0; rsp_seen = 0; since_ack = 0;
            if (reload[cur_owner] > 0) begin
                reload[cur_owner]--; load_msg(cur_owner, $urandom_range(0, 6));
            end
            chk_start_lat = any_active();
        end
    endtask

    task automatic step();
        @(posedge clk); #1; drive(); @(negedge clk); observe();
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while ((any_active() || in_txn) && k < budget) begin step(); k++; end
        check("done_in_time", k < budget, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, req_ready, rsp_valid, rsp_digest, rsp_err, core_start, core_dr, core_data, core_eof}, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0; #1;
        model_reset(); drive();
        check_all_zero("reset_async_outs");
        step(); step();
        check_all_zero("reset_held_outs");
        rst_n = 1'b1;
    endtask

    task automatic new_test();
        grant_log.delete(); starts = 0; tot_beats = 0; bp_cycles = 0; bp_viol = 0;
        fixed_dig = 0; hang = 0; eager_en = 0; stall_en = 0; junk_en = 0; rtr_pct = 100; bp_at = -1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset_outs");
        rst_n = 1'b1;
        step();

        // 1: single message, fixed digest
        new_test(); fixed_dig = 1;
        msg[0][0] = 8'h11; msg[0][1] = 8'h22; msg[0][2] = 8'h33;
        len[0] = 3; sent[0] = 0; active[0] = 1;
        run_until_done(200);
        check("t1_starts", starts, 1);
        check("t1_beats", tot_beats, 3);
        check("t1_rsp_vec", last_rsp, 4'b0001);
        check("t1_digest", last_dig, 32'hDEAD_BEEF);
        check("t1_err", last_err, 0);

        // 2: round-robin from reset, req0 requeued
        do_reset(); new_test(); rtr_pct = 70; stall_en = 1;
        for (int i = 0; i < N; i++) load_msg(i, $urandom_range(1, 5));
        reload[0] = 1;
        run_until_done(1000);
        check("t2_grants", grant_log.size(), 5);
        if (grant_log.size() == 5)
            check("t2_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0], grant_log[4][3:0]}, 20'h01230);

        // 3: backpressure mid-stream
        new_test(); bp_at = 2;
        load_msg(1, 6);
        run_until_done(300);
        check("t3_beats", tot_beats, 6);
        check("t3_bp_cycles", bp_cycles, 5);
        check("t3_bp_no_ready", bp_viol, 0);

        // 4: empty message
        new_test();
        load_msg(2, 0);
        run_until_done(200);
        check("t4_starts", starts, 1);
        check("t4_beats", tot_beats, 0);
        check("t4_rsp_vec", last_rsp, 4'b0100);

        // 5: watchdog, core never answers
        new_test(); hang = 1;
        load_msg(3, 2);
        run_until_done(5000);
        check("t5_rsp_vec", last_rsp, 4'b1000);
        check("t5_err", last_err, 1);
        check("t5_digest", last_dig, 32'h0);

        // 6: reset mid-stream, then req1/req3 together
        new_test(); rtr_pct = 50;
        load_msg(0, 20);
        begin
            int k = 0;
            while (sent[0] < 3 && k < 200) begin step(); k++; end
            check("t6_reached_stream", sent[0] >= 3, 1);
        end
        do_reset(); new_test();
        load_msg(1, 3); load_msg(3, 2);
        run_until_done(300);
        check("t6_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("t6_first", grant_log[0], 1);

        // Random traffic: stalls, eager H_ready, junk handshakes
        for (int r = 0; r < 6; r++) begin
            new_test(); stall_en = 1; junk_en = 1; rtr_pct = 60; eager_en = $urandom_range(0, 1);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) < 7) begin
                    load_msg(i, $urandom_range(0, 8)); reload[i] = $urandom_range(0, 1);
                end
            run_until_done(3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit.
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule
